nucore_ctrl: RTL

Multi-cycle control sequencer for the nucore datapath. It latches the opcode of each 39-bit instruction, walks a FETCH/DECODE/EXEC/MEM/WB state machine, and drives the register-file, ALU, PC and data-memory strobes. It handles a req/ack handshake to data memory and resolves branches from the ALU `zero` flag. It sits between instruction memory and the datapath, replacing hard-wired single-cycle control inside nucore.

---
 rtl/nucore_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/nucore_ctrl.sv
// nucore_ctrl: multi-cycle control sequencer for the nucore datapath.
// Walks FETCH/DECODE/EXEC/(MEM)/WB per instruction and drives registered
// datapath strobes. key[0] is the clock; key[1] is the async active-low reset.
// Optional feature: define NUCORE_CTRL_PERF_EN to build the retired and
// stall_cycles performance counters; otherwise both ports are tied to 0.
module nucore_ctrl #(
  parameter int OPW = 4
) (
  input  logic [1:0]  key,
  input  logic [38:0] inst,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        ir_load,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        rf_we,
  output logic        wb_sel_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [31:0] stall_cycles
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_t;

  logic           clk;
  logic           rst_n;
  state_t         state;
  state_t         state_nx;
  logic [OPW-1:0] opcode;
  logic           taken;
  logic           taken_nx;
  logic           unused_inst;

  assign clk         = key[0];
  assign rst_n       = key[1];
  assign unused_inst = ^inst[38-OPW:0];

  alu_t dec_alu;
  logic dec_imm, dec_rf, dec_lw, dec_sw, dec_beq, dec_jmp, dec_halt, dec_ill;

  // Opcode decode of the latched instruction
  always_comb begin
    dec_alu  = ALU_ADD;
    dec_imm  = 1'b0;
    dec_rf   = 1'b0;
    dec_lw   = 1'b0;
    dec_sw   = 1'b0;
    dec_beq  = 1'b0;
    dec_jmp  = 1'b0;
    dec_halt = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OPW'(4'h0): dec_alu = ALU_ADD;
      OPW'(4'h1): begin dec_alu = ALU_ADD; dec_rf = 1'b1; end
      OPW'(4'h2): begin dec_alu = ALU_SUB; dec_rf = 1'b1; end
      OPW'(4'h3): begin dec_alu = ALU_AND; dec_rf = 1'b1; end
      OPW'(4'h4): begin dec_alu = ALU_OR;  dec_rf = 1'b1; end
      OPW'(4'h5): begin dec_alu = ALU_XOR; dec_rf = 1'b1; end
      OPW'(4'h6): begin dec_imm = 1'b1; dec_rf = 1'b1; end
      OPW'(4'h7): begin dec_imm = 1'b1; dec_rf = 1'b1; dec_lw = 1'b1; end
      OPW'(4'h8): begin dec_imm = 1'b1; dec_sw = 1'b1; end
      OPW'(4'h9): begin dec_alu = ALU_SUB; dec_beq = 1'b1; end
      OPW'(4'hA): dec_jmp = 1'b1;
      OPW'(4'hF): dec_halt = 1'b1;
      default:    dec_ill = 1'b1;
    endcase
  end

  // Next state, branch resolution and next values of the registered outputs
  logic       ir_load_nx, alu_src_imm_nx, rf_we_nx, wb_sel_mem_nx;
  logic       mem_req_nx, mem_we_nx, pc_en_nx, pc_sel_nx, halted_nx, illegal_nx;
  logic [2:0] alu_op_nx;
  logic       in_exec_phase;

  always_comb begin
    state_nx = state;
    taken_nx = taken;
    case (state)
      // ir_load is low only in the first FETCH cycle after reset; that cycle
      // raises it, and the following edge latches the opcode and moves on.
      S_FETCH:  if (ir_load) state_nx = S_DECODE;
      S_DECODE: state_nx = (dec_halt || dec_ill) ? S_HALT : S_EXEC;
      S_EXEC: begin
        taken_nx = (dec_beq && zero) || dec_jmp;
        state_nx = (dec_lw || dec_sw) ? S_MEM : S_WB;
      end
      S_MEM:    if (mem_ack) state_nx = S_WB;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase

    in_exec_phase  = (state_nx == S_EXEC) || (state_nx == S_MEM) || (state_nx == S_WB);
    ir_load_nx     = (state_nx == S_FETCH);
    alu_op_nx      = in_exec_phase ? dec_alu : 3'd0;
    alu_src_imm_nx = in_exec_phase && dec_imm;
    mem_req_nx     = (state_nx == S_MEM);
    mem_we_nx      = (state_nx == S_MEM) && dec_sw;
    pc_en_nx       = (state_nx == S_WB);
    pc_sel_nx      = (state_nx == S_WB) && taken_nx;
    rf_we_nx       = (state_nx == S_WB) && dec_rf;
    wb_sel_mem_nx  = (state_nx == S_WB) && dec_lw;
    halted_nx      = (state_nx == S_HALT);
    illegal_nx     = illegal || ((state == S_DECODE) && dec_ill);
  end

  // State, latched opcode and branch decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      opcode <= '0;
      taken  <= 1'b0;
    end else begin
      state <= state_nx;
      taken <= taken_nx;
      if (state == S_FETCH && ir_load) opcode <= inst[38 -: OPW];
    end
  end

  // Registered datapath strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_load     <= 1'b0;
      alu_op      <= '0;
      alu_src_imm <= 1'b0;
      rf_we       <= 1'b0;
      wb_sel_mem  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      pc_en       <= 1'b0;
      pc_sel      <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      ir_load     <= ir_load_nx;
      alu_op      <= alu_op_nx;
      alu_src_imm <= alu_src_imm_nx;
      rf_we       <= rf_we_nx;
      wb_sel_mem  <= wb_sel_mem_nx;
      mem_req     <= mem_req_nx;
      mem_we      <= mem_we_nx;
      pc_en       <= pc_en_nx;
      pc_sel      <= pc_sel_nx;
      halted      <= halted_nx;
      illegal     <= illegal_nx;
    end
  end

`ifdef NUCORE_CTRL_PERF_EN
  // Retired-instruction and MEM-stall counters; both idle in HALT by construction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (pc_en) retired <= retired + 32'd1;
      if (state == S_MEM && !mem_ack) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign retired      = '0;
  assign stall_cycles = '0;
`endif

endmodule
